// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM block: step-divider
// arithmetic, mode encoding, direction encoding and fill-factor clamping.
package pwm_pkg;

    localparam logic PWM_MODE_EDGE   = 1'b0;
    localparam logic PWM_MODE_CENTER = 1'b1;

    // Direction of the triangle counter in center-aligned mode.
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } pwm_dir_e;

    // Clocks per counter tick; never below one so the counter always moves.
    function automatic int calc_step_divider(input int clk_hz, input int pwm_hz, input int max_value);
        int div;
        div = clk_hz / (pwm_hz * max_value);
        return (div < 1) ? 1 : div;
    endfunction

    // Saturate a requested fill factor at full scale.
    function automatic logic [31:0] clamp_fill(input logic [31:0] value, input logic [31:0] max_value);
        return (value > max_value) ? max_value : value;
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Shared PWM timebase: prescaler, period counter, triangle direction flag
// and period-boundary detection. The triangle counting and the mode input
// exist only when PWM_CENTER_ALIGN_EN is defined.
//
// o_boundary is the combinational tick that enters count 0 at the start of
// an up phase (including the first tick after enable); o_period_first is the
// same event registered, i.e. high for the one clock in which count 0 of a
// new period is first presented.
module pwm_timebase #(
    parameter int STEP_DIVIDER = 1,
    parameter int MAX_VALUE    = 4,
    parameter int CNT_W        = (MAX_VALUE > 1) ? $clog2(MAX_VALUE) : 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_enable,
`ifdef PWM_CENTER_ALIGN_EN
    input  logic             i_mode,
`endif
    output logic [CNT_W-1:0] o_count,
    output logic             o_running,
    output logic             o_boundary,
    output logic             o_period_first
);
    import pwm_pkg::*;

    localparam int               PRE_W    = (STEP_DIVIDER > 1) ? $clog2(STEP_DIVIDER) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(STEP_DIVIDER - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_VALUE - 1);

    logic [PRE_W-1:0] r_prescale;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;
    logic             r_running;
    logic             r_period_first;
    logic             w_tick;
    logic             w_boundary;
`ifdef PWM_CENTER_ALIGN_EN
    pwm_dir_e         r_dir;
    pwm_dir_e         w_dir_next;
    logic             r_mode;
`endif

    assign w_tick = i_enable && (r_prescale == PRE_LAST);

    // Prescaler: free-runs while enabled, parked at 0 otherwise.
    always_ff @(posedge i_clk) begin
        if (i_reset || !i_enable || w_tick) begin
            r_prescale <= '0;
        end else begin
            r_prescale <= r_prescale + 1'b1;
        end
    end

    // Next count / direction and boundary detection for the current tick.
    always_comb begin
        w_count_next = r_count;
        w_boundary   = 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
        w_dir_next   = r_dir;
`endif
        if (w_tick) begin
            if (!r_running) begin
                // First tick after enable or reset opens a fresh period at 0.
                w_count_next = '0;
                w_boundary   = 1'b1;
            end
`ifdef PWM_CENTER_ALIGN_EN
            else if (r_mode == PWM_MODE_CENTER) begin
                if (r_dir == DIR_UP) begin
                    if (r_count == CNT_LAST) begin
                        w_dir_next = DIR_DOWN;
                    end else begin
                        w_count_next = r_count + 1'b1;
                    end
                end else begin
                    if (r_count == '0) begin
                        w_dir_next = DIR_UP;
                        w_boundary = 1'b1;
                    end else begin
                        w_count_next = r_count - 1'b1;
                    end
                end
            end
`endif
            else if (r_count == CNT_LAST) begin
                w_count_next = '0;
                w_boundary   = 1'b1;
            end else begin
                w_count_next = r_count + 1'b1;
            end
        end
    end

    // Counter state register; disable parks everything at count 0, going up.
    always_ff @(posedge i_clk) begin
        if (i_reset || !i_enable) begin
            r_count        <= '0;
            r_running      <= 1'b0;
            r_period_first <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
            r_dir          <= DIR_UP;
`endif
        end else begin
            r_count        <= w_count_next;
            r_period_first <= w_boundary;
            if (w_tick) begin
                r_running <= 1'b1;
            end
`ifdef PWM_CENTER_ALIGN_EN
            r_dir          <= w_dir_next;
`endif
        end
    end

`ifdef PWM_CENTER_ALIGN_EN
    // Active mode changes only at a boundary, or freely while disabled.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_mode <= PWM_MODE_EDGE;
        end else if (!i_enable || w_boundary) begin
            r_mode <= i_mode;
        end
    end
`endif

    assign o_count        = r_count;
    assign o_running      = r_running;
    assign o_boundary     = w_boundary;
    assign o_period_first = r_period_first;

endmodule

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM generator: CHANNELS outputs share one timebase, each
// with a double-buffered (pending -> active) fill factor. Define
// PWM_CENTER_ALIGN_EN to add the IN_MODE port and center-aligned counting;
// without it the block is edge-aligned only.
module pwm_multi_channel #(
    parameter int CLOCK_FREQUENCY  = 400000,
    parameter int PWM_FREQUENCY    = 100000,
    parameter int MAX_VALUE        = 4,
    parameter int CHANNELS         = 2,
    parameter int DEEP_FILL_FACTOR = $clog2(MAX_VALUE) + 1
) (
    input  logic                                 IN_CLOCK,
    input  logic                                 IN_RESET,
    input  logic                                 IN_ENABLE,
    input  logic [CHANNELS*DEEP_FILL_FACTOR-1:0] IN_FILL_FACTOR,
    input  logic                                 IN_LOAD,
`ifdef PWM_CENTER_ALIGN_EN
    input  logic                                 IN_MODE,
`endif
    output logic [CHANNELS-1:0]                  OUT_PWM_SIGNAL,
    output logic                                 OUT_PERIOD_START
);
    import pwm_pkg::*;

    localparam int STEP_DIVIDER = calc_step_divider(CLOCK_FREQUENCY, PWM_FREQUENCY, MAX_VALUE);
    localparam int CNT_W        = (MAX_VALUE > 1) ? $clog2(MAX_VALUE) : 1;
    localparam int DW           = DEEP_FILL_FACTOR;

    logic [CNT_W-1:0]    w_count;
    logic                w_running;
    logic                w_boundary;
    logic                w_period_first;
    logic [CHANNELS-1:0] w_high;
    logic [CHANNELS-1:0] r_pwm;
    logic                r_period_start;

    pwm_timebase #(
        .STEP_DIVIDER (STEP_DIVIDER),
        .MAX_VALUE    (MAX_VALUE),
        .CNT_W        (CNT_W)
    ) u_timebase (
        .i_clk          (IN_CLOCK),
        .i_reset        (IN_RESET),
        .i_enable       (IN_ENABLE),
`ifdef PWM_CENTER_ALIGN_EN
        .i_mode         (IN_MODE),
`endif
        .o_count        (w_count),
        .o_running      (w_running),
        .o_boundary     (w_boundary),
        .o_period_first (w_period_first)
    );

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        logic [DW-1:0] w_fill_in;
        logic [DW-1:0] w_pending_next;
        logic [DW-1:0] r_pending;
        logic [DW-1:0] r_active;

        assign w_fill_in = IN_FILL_FACTOR[ch*DW +: DW];
        // A load in the boundary clock bypasses straight into active.
        assign w_pending_next = IN_LOAD ? DW'(clamp_fill(32'(w_fill_in), 32'(MAX_VALUE))) : r_pending;

        // Pending captures loads; active follows it at boundaries or while disabled.
        always_ff @(posedge IN_CLOCK) begin
            if (IN_RESET) begin
                r_pending <= '0;
                r_active  <= '0;
            end else begin
                r_pending <= w_pending_next;
                if (!IN_ENABLE || w_boundary) begin
                    r_active <= w_pending_next;
                end
            end
        end

        assign w_high[ch] = (DW'(w_count) < r_active);
    end

    // Registered outputs, forced low while disabled or before the first tick.
    always_ff @(posedge IN_CLOCK) begin
        if (IN_RESET) begin
            r_pwm          <= '0;
            r_period_start <= 1'b0;
        end else begin
            r_pwm          <= (IN_ENABLE && w_running) ? w_high : '0;
            r_period_start <= IN_ENABLE && w_period_first;
        end
    end

    assign OUT_PWM_SIGNAL   = r_pwm;
    assign OUT_PERIOD_START = r_period_start;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Bench for pwm_multi_channel (defaults, CHANNELS=2). Scenario tasks run in
// sequence; a reference model derives the expected outputs from the period
// position (tick index within the period) and the double-buffer rules.
// Handshake note: the block has no valid/ready interfaces; IN_LOAD is a
// single-clock strobe sampled on the rising edge, outputs are registered.
module tb_pwm_multi_channel;
  localparam int CH = 2;
  localparam int MAXV = 4;
  localparam int DW = $clog2(MAXV) + 1;
  localparam int FW = CH * DW;
  localparam int STEP_RAW = 400000 / (100000 * MAXV);
  localparam int STEP = (STEP_RAW < 1) ? 1 : STEP_RAW;

  // clock / reset block
  logic clk = 1'b0;
  logic rst;
  logic en;
  logic load;
  logic [FW-1:0] fill;
`ifdef PWM_CENTER_ALIGN_EN
  logic mode;
`endif
  logic [CH-1:0] pwm;
  logic ps;

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [CH:0] exp_q[$];
  logic [CH:0] exp_v;

  pwm_multi_channel dut (
    .IN_CLOCK(clk),
    .IN_RESET(rst),
    .IN_ENABLE(en),
    .IN_FILL_FACTOR(fill),
    .IN_LOAD(load),
`ifdef PWM_CENTER_ALIGN_EN
    .IN_MODE(mode),
`endif
    .OUT_PWM_SIGNAL(pwm),
    .OUT_PERIOD_START(ps)
  );

  // reference model: period position as a tick index, count derived from it
  int m_pend[CH];
  int m_act[CH];
  int m_pn[CH];
  int m_idx = 0;
  int m_clk = 0;
  int m_cnt;
  int m_v;
  bit m_run = 1'b0;
  bit m_first = 1'b0;
  bit m_mode = 1'b0;
  bit m_mode_in;
  bit m_tick;
  bit m_bnd;
  logic [CH:0] m_e;

  always @(posedge clk) begin
`ifdef PWM_CENTER_ALIGN_EN
    m_mode_in = mode;
`else
    m_mode_in = 1'b0;
`endif
    m_e = '0;
    if (rst) begin
      for (int ch = 0; ch < CH; ch++) begin
        m_pend[ch] = 0;
        m_act[ch] = 0;
      end
      m_idx = 0; m_clk = 0; m_run = 0; m_first = 0; m_mode = 0;
    end else begin
      for (int ch = 0; ch < CH; ch++) begin
        m_v = int'(fill[ch*DW +: DW]);
        m_pn[ch] = load ? ((m_v > MAXV) ? MAXV : m_v) : m_pend[ch];
      end
      m_cnt = (m_mode && m_idx >= MAXV) ? (2 * MAXV - 1 - m_idx) : m_idx;
      for (int ch = 0; ch < CH; ch++)
        m_e[ch] = en && m_run && (m_cnt < m_act[ch]);
      m_e[CH] = en && m_first;
      if (!en) begin
        m_run = 0; m_idx = 0; m_clk = 0; m_first = 0;
        m_act = m_pn;
        m_mode = m_mode_in;
      end else begin
        m_tick = (m_clk == STEP - 1);
        m_clk = m_tick ? 0 : m_clk + 1;
        m_bnd = m_tick && (!m_run || m_idx == (m_mode ? 2 * MAXV : MAXV) - 1);
        m_first = m_bnd;
        if (m_tick) begin
          m_run = 1;
          m_idx = m_bnd ? 0 : m_idx + 1;
        end
        if (m_bnd) begin
          m_act = m_pn;
          m_mode = m_mode_in;
        end
      end
      m_pend = m_pn;
    end
    exp_q.push_back(m_e);
  end

  function automatic logic [FW-1:0] pack2(input int a, input int b);
    logic [DW-1:0] la;
    logic [DW-1:0] lb;
    la = DW'(a);
    lb = DW'(b);
    return {lb, la};
  endfunction

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; load = 1'b0; fill = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      exp_v = exp_q.pop_front();
      total++;
      if ({ps, pwm} !== exp_v) begin
        bad++; $display("FAIL reset_model t=%0t got=%b exp=%b", $time, {ps, pwm}, exp_v);
      end
      total++;
      if ({ps, pwm} !== 3'b000) begin
        bad++; $display("FAIL reset_value t=%0t got=%b exp=000", $time, {ps, pwm});
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int k = 0, n_ps = 0, n0 = 0, n1 = 0;
    bit seen = 0;
    fill = pack2(2, 1); load = 1'b1;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      exp_v = exp_q.pop_front();
      total++;
      if ({ps, pwm} !== exp_v) begin
        bad++; $display("FAIL basic_model t=%0t got=%b exp=%b", $time, {ps, pwm}, exp_v);
      end
      if (ps) seen = 1;
      if (seen && k < 12) begin
        n_ps += int'(ps); n0 += int'(pwm[0]); n1 += int'(pwm[1]); k++;
      end
      if (c == 0) begin load = 1'b0; en = 1'b1; end
    end
    total++;
    if (k != 12 || n_ps != 3) begin
      bad++; $display("FAIL basic_period_pulses got=%0d in %0d clocks exp=3 in 12", n_ps, k);
    end
    total++;
    if (n0 != 6) begin bad++; $display("FAIL basic_ch0_duty got=%0d exp=6", n0); end
    total++;
    if (n1 != 3) begin bad++; $display("FAIL basic_ch1_duty got=%0d exp=3", n1); end
  endtask

  task automatic test_midload();
    int pos = -1, n_cur = 0, n_next = 0;
    logic ps4 = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      exp_v = exp_q.pop_front();
      total++;
      if ({ps, pwm} !== exp_v) begin
        bad++; $display("FAIL midload_model t=%0t got=%b exp=%b", $time, {ps, pwm}, exp_v);
      end
      if (pos < 0 && ps) pos = 0;
      else if (pos >= 0) pos++;
      if (pos >= 0 && pos < 4) n_cur += int'(pwm[0]);
      if (pos >= 4 && pos < 8) n_next += int'(pwm[0]);
      if (pos == 4) ps4 = ps;
      if (pos == 0) begin fill = pack2(3, 1); load = 1'b1; end
      if (pos == 1) load = 1'b0;
    end
    total++;
    if (n_cur != 2) begin bad++; $display("FAIL midload_current got=%0d exp=2", n_cur); end
    total++;
    if (n_next != 3) begin bad++; $display("FAIL midload_next got=%0d exp=3", n_next); end
    total++;
    if (ps4 !== 1'b1) begin bad++; $display("FAIL midload_boundary got=%b exp=1", ps4); end
  endtask

  task automatic test_clamp();
    int vals[3] = '{0, 4, 7};
    int pos;
    logic lv;
    for (int i = 0; i < 3; i++) begin
      fill = pack2(vals[i], 7 - vals[i]); load = 1'b1;
      lv = (vals[i] != 0);
      pos = -1;
      for (int c = 0; c < 14; c++) begin
        @(negedge clk);
        exp_v = exp_q.pop_front();
        total++;
        if ({ps, pwm} !== exp_v) begin
          bad++; $display("FAIL clamp_model t=%0t got=%b exp=%b", $time, {ps, pwm}, exp_v);
        end
        if (pos < 0 && c >= 1 && ps) pos = 0;
        else if (pos >= 0) pos++;
        if (pos >= 0 && pos < 4) begin
          total++;
          if (pwm[0] !== lv) begin
            bad++; $display("FAIL clamp_level v=%0d t=%0t got=%b exp=%b", vals[i], $time, pwm[0], lv);
          end
        end
        if (c == 0) load = 1'b0;
      end
      total++;
      if (pos < 3) begin bad++; $display("FAIL clamp_wait v=%0d got=%0d exp>=3", vals[i], pos); end
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 26; c++) begin
      @(negedge clk);
      exp_v = exp_q.pop_front();
      total++;
      if ({ps, pwm} !== exp_v) begin
        bad++; $display("FAIL reset_mid_model t=%0t got=%b exp=%b", $time, {ps, pwm}, exp_v);
      end
      if (c >= 2 && c <= 13) begin
        total++;
        if (pwm !== '0) begin
          bad++; $display("FAIL reset_mid_low t=%0t got=%b exp=00", $time, pwm);
        end
      end
      if (c == 1) rst = 1'b1;
      if (c == 4) rst = 1'b0;
      if (c == 13) begin fill = pack2(2, 3); load = 1'b1; end
      if (c == 14) load = 1'b0;
    end
  endtask

  task automatic test_disable();
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      exp_v = exp_q.pop_front();
      total++;
      if ({ps, pwm} !== exp_v) begin
        bad++; $display("FAIL disable_model t=%0t got=%b exp=%b", $time, {ps, pwm}, exp_v);
      end
      if (c >= 3 && c <= 7) begin
        total++;
        if ({ps, pwm} !== 3'b000) begin
          bad++; $display("FAIL disable_low t=%0t got=%b exp=000", $time, {ps, pwm});
        end
      end
      if (c == 9) begin
        total++;
        if (ps !== 1'b1 || pwm[0] !== 1'b1) begin
          bad++; $display("FAIL reenable_first got ps=%b ch0=%b exp ps=1 ch0=1", ps, pwm[0]);
        end
      end
      if (c == 10) begin
        total++;
        if (pwm[0] !== 1'b0) begin
          bad++; $display("FAIL reenable_second got ch0=%b exp ch0=0", pwm[0]);
        end
      end
      if (c == 2) begin en = 1'b0; fill = pack2(1, 0); load = 1'b1; end
      if (c == 3) load = 1'b0;
      if (c == 7) en = 1'b1;
    end
  endtask

`ifdef PWM_CENTER_ALIGN_EN
  task automatic test_center();
    int ps_pos[$];
    logic hist[48];
    int p;
    mode = 1'b1; fill = pack2(1, 3); load = 1'b1;
    for (int c = 0; c < 48; c++) begin
      @(negedge clk);
      exp_v = exp_q.pop_front();
      total++;
      if ({ps, pwm} !== exp_v) begin
        bad++; $display("FAIL center_model t=%0t got=%b exp=%b", $time, {ps, pwm}, exp_v);
      end
      hist[c] = pwm[0];
      if (ps) ps_pos.push_back(c);
      if (c == 0) load = 1'b0;
    end
    total++;
    if (ps_pos.size() < 4) begin
      bad++; $display("FAIL center_wait got=%0d pulses exp>=4", ps_pos.size());
    end else begin
      total++;
      if (ps_pos[3] - ps_pos[2] != 8) begin
        bad++; $display("FAIL center_period got=%0d exp=8", ps_pos[3] - ps_pos[2]);
      end
      p = ps_pos[2];
      total++;
      if ({hist[p-2], hist[p-1], hist[p], hist[p+1]} !== 4'b0110) begin
        bad++; $display("FAIL center_pulse got=%b exp=0110", {hist[p-2], hist[p-1], hist[p], hist[p+1]});
      end
    end
    mode = 1'b0;
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      exp_v = exp_q.pop_front();
      total++;
      if ({ps, pwm} !== exp_v) begin
        bad++; $display("FAIL random_model t=%0t got=%b exp=%b", $time, {ps, pwm}, exp_v);
      end
      rst = ($urandom_range(0, 59) == 0);
      en = ($urandom_range(0, 11) != 0);
      load = ($urandom_range(0, 3) == 0);
      fill = FW'($urandom);
`ifdef PWM_CENTER_ALIGN_EN
      if ($urandom_range(0, 29) == 0) mode = ~mode;
`endif
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; fill = '0;
`ifdef PWM_CENTER_ALIGN_EN
    mode = 1'b0;
`endif
    test_reset();
    test_basic();
    test_midload();
    test_clamp();
    test_reset_mid();
    test_disable();
`ifdef PWM_CENTER_ALIGN_EN
    test_center();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
